// File: rtl/full_chip.sv
// full_chip: single attention core.
// Q/K row memories feed a weight-stationary array of col signed dot-product
// columns; each executed Q row yields one col-wide psum word that passes
// through a fall-through output FIFO into the psum memory (pmem), which is
// read back on out.
module full_chip #(
    parameter int bw      = 4,
    parameter int pr      = 8,
    parameter int col     = 8,
    parameter int bw_psum = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [pr*bw-1:0]       mem_in,
    input  logic [16:0]            inst,
    output logic [col*bw_psum-1:0] out
);

    localparam int MEM_DEPTH  = 16;
    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int LCNT_W     = $clog2(col + 1);
    localparam int ROW_W      = pr * bw;
    localparam int WORD_W     = col * bw_psum;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic              ofifo_rd;
    logic [ADDR_W-1:0] qkmem_add;
    logic [ADDR_W-1:0] pmem_add;
    logic              execute;
    logic              load;
    logic              qmem_rd;
    logic              qmem_wr;
    logic              kmem_rd;
    logic              kmem_wr;
    logic              pmem_rd;
    logic              pmem_wr;

    assign ofifo_rd  = inst[16];
    assign qkmem_add = inst[15:12];
    assign pmem_add  = inst[11:8];
    assign execute   = inst[7];
    assign load      = inst[6];
    assign qmem_rd   = inst[5];
    assign qmem_wr   = inst[4];
    assign kmem_rd   = inst[3];
    assign kmem_wr   = inst[2];
    assign pmem_rd   = inst[1];
    assign pmem_wr   = inst[0];

    // ------------------------------------------------------------------
    // Q and K memories: registered read, old data on same-address rd+wr
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] qmem_array [MEM_DEPTH];
    logic [ROW_W-1:0] kmem_array [MEM_DEPTH];
    logic [ROW_W-1:0] q_data_reg;
    logic [ROW_W-1:0] k_data_reg;
    logic             q_valid_reg;
    logic             k_valid_reg;

    // Q memory array write and registered read port
    always_ff @(posedge clk) begin
        if (qmem_wr)
            qmem_array[qkmem_add] <= mem_in;
        if (qmem_rd)
            q_data_reg <= qmem_array[qkmem_add];
    end

    // K memory array write and registered read port
    always_ff @(posedge clk) begin
        if (kmem_wr)
            kmem_array[qkmem_add] <= mem_in;
        if (kmem_rd)
            k_data_reg <= kmem_array[qkmem_add];
    end

    // Read-valid flags mark the cycle in which q/k_data_reg is fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid_reg <= 1'b0;
            k_valid_reg <= 1'b0;
        end else begin
            q_valid_reg <= qmem_rd;
            k_valid_reg <= kmem_rd;
        end
    end

    // ------------------------------------------------------------------
    // Weight loading: successive valid K rows fill columns 0,1,2,...
    // ------------------------------------------------------------------
    logic [LCNT_W-1:0] load_cnt_reg;
    logic              load_fire;
    logic [ROW_W-1:0]  weight_reg [col];

    assign load_fire = load && k_valid_reg && (load_cnt_reg < LCNT_W'(col));

    // Load counter: restarts whenever load drops, saturates once all columns hold a row
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            load_cnt_reg <= '0;
        else if (!load)
            load_cnt_reg <= '0;
        else if (load_fire)
            load_cnt_reg <= load_cnt_reg + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_weight
            // Column gi captures the K row arriving while the counter points at it
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    weight_reg[gi] <= '0;
                else if (load_fire && (load_cnt_reg == LCNT_W'(gi)))
                    weight_reg[gi] <= k_data_reg;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // MAC array: all columns compute Q . W[c] in parallel
    // ------------------------------------------------------------------
    logic                 exec_fire;
    logic [bw_psum-1:0]   psum_comb [col];
    logic [WORD_W-1:0]    psum_flat;
    logic [WORD_W-1:0]    psum_reg;
    logic                 psum_valid_reg;

    // Loading has priority: a Q row presented during load is not executed
    assign exec_fire = execute && !load && q_valid_reg;

    generate
        for (gi = 0; gi < col; gi++) begin : g_mac
            // Sign-extended lane products summed at psum width; the range of
            // pr products of bw-bit operands fits bw_psum, so no wrap occurs
            always_comb begin
                logic [bw_psum-1:0] acc;
                logic [bw_psum-1:0] q_ext;
                logic [bw_psum-1:0] w_ext;
                acc   = '0;
                q_ext = '0;
                w_ext = '0;
                for (int k = 0; k < pr; k++) begin
                    q_ext = {{(bw_psum-bw){q_data_reg[bw*k+bw-1]}}, q_data_reg[bw*k +: bw]};
                    w_ext = {{(bw_psum-bw){weight_reg[gi][bw*k+bw-1]}}, weight_reg[gi][bw*k +: bw]};
                    acc   = acc + q_ext * w_ext;
                end
                psum_comb[gi] = acc;
            end
            assign psum_flat[bw_psum*gi +: bw_psum] = psum_comb[gi];
        end
    endgenerate

    // One-cycle result register; reset discards any in-flight word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_reg       <= '0;
            psum_valid_reg <= 1'b0;
        end else begin
            psum_valid_reg <= exec_fire;
            if (exec_fire)
                psum_reg <= psum_flat;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO, first-word fall-through
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] ofifo_array [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] fifo_head;

    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // A word arriving while full is dropped even if a pop happens in the same cycle
    assign push       = psum_valid_reg && !fifo_full;
    assign pop        = ofifo_rd && !fifo_empty;
    assign fifo_head  = fifo_empty ? '0 : ofifo_array[rd_ptr_reg];

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push)
            ofifo_array[wr_ptr_reg] <= psum_reg;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Psum memory: captures the FIFO head (zero when empty), read to out
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] pmem_array [MEM_DEPTH];

    // pmem write of the current FIFO head
    always_ff @(posedge clk) begin
        if (pmem_wr)
            pmem_array[pmem_add] <= fifo_head;
    end

    // Registered pmem read; out holds its value between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out <= '0;
        else if (pmem_rd)
            out <= pmem_array[pmem_add];
    end

endmodule

// File: tb/tb_full_chip.sv
// tb_full_chip: directed self-checking bench for full_chip.
// Expected words come from hand constants or a small dot-product model over
// the bench's own copies of the Q and K rows.
`timescale 1ns/1ps
module tb_full_chip;

    localparam int BW      = 4;
    localparam int PR      = 8;
    localparam int COL     = 8;
    localparam int BW_PSUM = 11;
    localparam int WORD_W  = COL * BW_PSUM;

    logic              clk;
    logic              reset;
    logic [PR*BW-1:0]  mem_in;
    logic [16:0]       inst;
    logic [WORD_W-1:0] out;

    logic       ofifo_rd, execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr;
    logic [3:0] qk_add, p_add;

    assign inst = {ofifo_rd, qk_add, p_add, execute, load, qmem_rd, qmem_wr,
                   kmem_rd, kmem_wr, pmem_rd, pmem_wr};

    full_chip #(.bw(BW), .pr(PR), .col(COL), .bw_psum(BW_PSUM)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_in (mem_in),
        .inst   (inst),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [PR*BW-1:0] q_rows [16];
    logic [PR*BW-1:0] k_rows [COL];

    task automatic check_val(input string tag, input logic [WORD_W-1:0] got,
                             input logic [WORD_W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Golden word for Q row qi against the K rows currently in k_rows
    function automatic logic [WORD_W-1:0] golden(input int qi);
        logic [WORD_W-1:0] w;
        logic signed [31:0] s;
        int a, b;
        w = '0;
        for (int c = 0; c < COL; c++) begin
            s = 0;
            for (int k = 0; k < PR; k++) begin
                a = int'($signed(q_rows[qi][BW*k +: BW]));
                b = int'($signed(k_rows[c][BW*k +: BW]));
                s = s + a * b;
            end
            w[BW_PSUM*c +: BW_PSUM] = s[BW_PSUM-1:0];
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inst();
        ofifo_rd = 0; execute = 0; load = 0; qmem_rd = 0; qmem_wr = 0;
        kmem_rd = 0; kmem_wr = 0; pmem_rd = 0; pmem_wr = 0;
        qk_add = '0; p_add = '0; mem_in = '0;
    endtask

    task automatic write_row(input bit is_k, input logic [3:0] addr, input logic [PR*BW-1:0] data);
        clear_inst();
        qk_add = addr;
        mem_in = data;
        if (is_k) kmem_wr = 1; else qmem_wr = 1;
        step();
        clear_inst();
    endtask

    // Write bench copies of K rows into kmem and Q rows 0..nq-1 into qmem
    task automatic write_all(input int nq);
        for (int i = 0; i < COL; i++) write_row(1'b1, 4'(i), k_rows[i]);
        for (int i = 0; i < nq; i++) write_row(1'b0, 4'(i), q_rows[i]);
    endtask

    // 8 kmem reads with load held one extra cycle for the read latency
    task automatic load_k();
        clear_inst();
        for (int i = 0; i <= COL; i++) begin
            load    = 1;
            kmem_rd = (i < COL);
            qk_add  = 4'(i);
            step();
        end
        clear_inst();
        step();
    endtask

    task automatic exec_rows(input int start, input int n);
        clear_inst();
        for (int i = 0; i <= n; i++) begin
            execute = 1;
            qmem_rd = (i < n);
            qk_add  = 4'(start + i);
            step();
        end
        clear_inst();
        step();
        step();
    endtask

    task automatic drain(input int dst, input int n);
        clear_inst();
        for (int i = 0; i < n; i++) begin
            ofifo_rd = 1;
            pmem_wr  = 1;
            p_add    = 4'(dst + i);
            step();
        end
        clear_inst();
    endtask

    task automatic read_pmem(input int addr, output logic [WORD_W-1:0] v);
        clear_inst();
        pmem_rd = 1;
        p_add   = 4'(addr);
        step();
        clear_inst();
        v = out;
    endtask

    logic [WORD_W-1:0] rd_val;
    logic [WORD_W-1:0] exp_val;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inst();
        reset = 1;

        // ---- 1: reset state ----
        repeat (3) step();
        check_val("t1_reset_out", out, '0);
        #2 reset = 0;
        repeat (10) step();
        check_val("t1_idle_out", out, '0);
        drain(0, 1);
        read_pmem(0, rd_val);
        check_val("t1_fifo_empty", rd_val, '0);

        // ---- 2: Q all 1, K[c] all c -> column c = 8*c ----
        for (int c = 0; c < COL; c++) k_rows[c] = {8{4'(c)}};
        for (int i = 0; i < 8; i++) q_rows[i] = {8{4'h1}};
        write_all(8);
        load_k();
        exec_rows(0, 8);
        drain(0, 8);
        exp_val = '0;
        for (int c = 0; c < COL; c++) exp_val[BW_PSUM*c +: BW_PSUM] = 11'(8 * c);
        read_pmem(0, rd_val);
        check_val("t2_row0", rd_val, exp_val);
        read_pmem(7, rd_val);
        check_val("t2_row7", rd_val, exp_val);

        // ---- 3: signed extremes ----
        for (int c = 0; c < COL; c++) k_rows[c] = '0;
        k_rows[0] = {8{4'h7}};
        k_rows[1] = {8{4'h8}};
        q_rows[0] = {8{4'h8}};
        write_all(1);
        load_k();
        exec_rows(0, 1);
        drain(0, 1);
        read_pmem(0, rd_val);
        check_val("t3_neg8x7", {77'd0, rd_val[10:0]}, {77'd0, 11'h640});
        check_val("t3_neg8xneg8", {77'd0, rd_val[21:11]}, {77'd0, 11'h200});
        check_val("t3_zero_col", {77'd0, rd_val[32:22]}, '0);

        // ---- 4: random Q/K against the golden model ----
        for (int c = 0; c < COL; c++) k_rows[c] = $urandom;
        for (int i = 0; i < 8; i++) q_rows[i] = $urandom;
        write_all(8);
        load_k();
        exec_rows(0, 8);
        drain(0, 8);
        for (int i = 0; i < 8; i++) begin
            read_pmem(i, rd_val);
            check_val($sformatf("t4_row%0d", i), rd_val, golden(i));
        end

        // ---- 5: FIFO full / drop / order / empty pop ----
        for (int i = 0; i < 16; i++) q_rows[i] = $urandom;
        q_rows[5] = ~q_rows[0];
        for (int i = 0; i < 16; i++) write_row(1'b0, 4'(i), q_rows[i]);
        exec_rows(0, 16);
        exec_rows(5, 1);
        drain(0, 16);
        for (int i = 0; i < 16; i++) begin
            read_pmem(i, rd_val);
            check_val($sformatf("t5_fifo%0d", i), rd_val, golden(i));
        end
        drain(0, 1);
        read_pmem(0, rd_val);
        check_val("t5_pop_empty", rd_val, '0);
        exec_rows(3, 1);
        drain(1, 1);
        read_pmem(1, rd_val);
        check_val("t5_after_empty", rd_val, golden(3));

        // ---- 6: reset in the middle of execute ----
        load_k();
        clear_inst();
        for (int i = 0; i < 3; i++) begin
            execute = 1;
            qmem_rd = 1;
            qk_add  = 4'(i);
            step();
        end
        #2 reset = 1;
        #1;
        check_val("t6_async_out", out, '0);
        clear_inst();
        @(posedge clk);
        #3 reset = 0;
        step();
        drain(15, 1);
        read_pmem(15, rd_val);
        check_val("t6_fifo_empty", rd_val, '0);
        load_k();
        exec_rows(0, 8);
        drain(0, 8);
        for (int i = 0; i < 8; i++) begin
            read_pmem(i, rd_val);
            check_val($sformatf("t6_rerun%0d", i), rd_val, golden(i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
